// File: rtl/fetch_queue.sv
// fetch_queue: instruction FIFO between fetch and decode, head split into decode fields.
// Define FETCH_QUEUE_BYPASS_EN to present fetch inputs to decode combinationally while empty.
module fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic                  flush_in,
  input  logic                  fetch_valid_in,
  output logic                  fetch_ready_out,
  input  logic [31:0]           fetch_inst_in,
  input  logic [PC_WIDTH-1:0]   fetch_pc_in,
  output logic                  dec_valid_out,
  input  logic                  dec_ready_in,
  output logic [4:0]            opcode_out,
  output logic [2:0]            funct3_out,
  output logic [6:0]            funct7_out,
  output logic [4:0]            rs1_out,
  output logic [4:0]            rs2_out,
  output logic [4:0]            rd_out,
  output logic [31:0]           inst_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  illegal_out,
  output logic [$clog2(DEPTH):0] count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]         inst_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_q   [DEPTH];
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                empty, byp, push, pop;
  logic [31:0]         head_inst;
  logic [PC_WIDTH-1:0] head_pc;
  always_comb begin
    empty           = cnt_q == '0;
    fetch_ready_out = cnt_q < FULL;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp             = empty & fetch_valid_in & !flush_in;
`else
    byp             = 1'b0;
`endif
    dec_valid_out   = !empty | byp;
    head_inst       = !empty ? inst_q[rd_q] : byp ? fetch_inst_in : '0;
    head_pc         = !empty ? pc_q[rd_q]   : byp ? fetch_pc_in   : '0;
    // a bypassed instruction taken by decode in the same cycle is never stored
    push            = fetch_valid_in & fetch_ready_out & !flush_in & !(byp & dec_ready_in);
    pop             = !empty & dec_ready_in & !flush_in;
    wr_d            = flush_in ? '0 : wr_q + AW'(push);
    rd_d            = flush_in ? '0 : rd_q + AW'(pop);
    cnt_d           = flush_in ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  assign opcode_out  = head_inst[6:2];
  assign funct3_out  = head_inst[14:12];
  assign funct7_out  = head_inst[31:25];
  assign rs1_out     = head_inst[19:15];
  assign rs2_out     = head_inst[24:20];
  assign rd_out      = head_inst[11:7];
  assign inst_out    = head_inst;
  assign pc_out      = head_pc;
  assign illegal_out = dec_valid_out & (head_inst[1:0] != 2'b11);
  assign count_out   = cnt_q;
  always_ff @(posedge clock_in or negedge reset_n_in)
    if (!reset_n_in) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clock_in)
    if (push) begin
      inst_q[wr_q] <= fetch_inst_in;
      pc_q[wr_q]   <= fetch_pc_in;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed bench; a queue model predicts every presented head.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PW    = 32;
  logic clock_in = 0, reset_n_in = 0, flush_in = 0, fetch_valid_in = 0, dec_ready_in = 0;
  logic [31:0] fetch_inst_in = '0;
  logic [PW-1:0] fetch_pc_in = '0;
  logic fetch_ready_out, dec_valid_out, illegal_out;
  logic [4:0] opcode_out, rs1_out, rs2_out, rd_out;
  logic [2:0] funct3_out;
  logic [6:0] funct7_out;
  logic [31:0] inst_out;
  logic [PW-1:0] pc_out;
  logic [$clog2(DEPTH):0] count_out;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] inst; logic [PW-1:0] pc; } ent_t;
  ent_t exp_q[$];
  bit push_p = 0, flush_p = 0;

  fetch_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in), .flush_in(flush_in),
    .fetch_valid_in(fetch_valid_in), .fetch_ready_out(fetch_ready_out),
    .fetch_inst_in(fetch_inst_in), .fetch_pc_in(fetch_pc_in),
    .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
    .opcode_out(opcode_out), .funct3_out(funct3_out), .funct7_out(funct7_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .inst_out(inst_out), .pc_out(pc_out), .illegal_out(illegal_out), .count_out(count_out)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One cycle: commit last cycle's accepted transfer to the model, check status, drive new inputs.
  task automatic step(input logic fv, input logic [31:0] inst, input logic [PW-1:0] pc,
                      input logic dr, input logic fl);
    @(posedge clock_in);
    if (flush_p) exp_q.delete();
    else if (push_p) exp_q.push_back('{inst: fetch_inst_in, pc: fetch_pc_in});
    #1;
    chk("count", 64'(count_out), 64'(exp_q.size()));
    chk("fetch_ready", 64'(fetch_ready_out), 64'(exp_q.size() < DEPTH));
    chk("dec_valid", 64'(dec_valid_out), 64'(exp_q.size() != 0));
    fetch_valid_in = fv;
    fetch_inst_in  = inst;
    fetch_pc_in    = pc;
    dec_ready_in   = dr;
    flush_in       = fl;
    push_p  = fv && exp_q.size() < DEPTH && !fl;
    flush_p = fl;
  endtask

  task automatic idle_zero(input string name);
    chk({name, "_inst"}, 64'(inst_out), 64'd0);
    chk({name, "_pc"}, 64'(pc_out), 64'd0);
    chk({name, "_fields"}, 64'({illegal_out, opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out}), 64'd0);
  endtask

  always @(negedge clock_in) begin : monitor
    ent_t e;
    if (reset_n_in) begin
      if (dec_valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL head_unexpected actual=valid pc=%0h required=empty", pc_out);
        end else begin
          e = exp_q[0];
          chk("head_inst", 64'(inst_out), 64'(e.inst));
          chk("head_pc", 64'(pc_out), 64'(e.pc));
          chk("head_opcode", 64'(opcode_out), 64'(e.inst[6:2]));
          chk("head_funct3", 64'(funct3_out), 64'(e.inst[14:12]));
          chk("head_funct7", 64'(funct7_out), 64'(e.inst[31:25]));
          chk("head_regs", 64'({rs1_out, rs2_out, rd_out}), 64'({e.inst[19:15], e.inst[24:20], e.inst[11:7]}));
          chk("head_illegal", 64'(illegal_out), 64'(e.inst[1:0] != 2'b11));
          if (dec_ready_in && !flush_in) void'(exp_q.pop_front());
        end
      end else idle_zero("idle");
    end
  end

  initial begin
    #2;
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_ready", 64'(fetch_ready_out), 64'd1);
    chk("rst_valid", 64'(dec_valid_out), 64'd0);
    idle_zero("rst");
    #10 reset_n_in = 1;
    // add a0,a0,a1 at 0x100
    step(1, 32'h00B50533, 32'h100, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("add_opcode", 64'(opcode_out), 64'b01100);
    chk("add_f3f7", 64'({funct3_out, funct7_out}), 64'd0);
    chk("add_rs1", 64'(rs1_out), 64'd10);
    chk("add_rs2", 64'(rs2_out), 64'd11);
    chk("add_rd", 64'(rd_out), 64'd10);
    chk("add_pc", 64'(pc_out), 64'h100);
    chk("add_illegal", 64'(illegal_out), 64'd0);
    step(0, 0, 0, 0, 0);
    // fill to full, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1, 32'h13 | (i << 7), PW'(i * 4), 0, 0);
    step(0, 0, 0, 0, 0);
    chk("full_count", 64'(count_out), 64'(DEPTH));
    chk("full_ready", 64'(fetch_ready_out), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 1, 0);
      chk("drain_pc", 64'(pc_out), 64'(i * 4));
    end
    step(0, 0, 0, 0, 0);
    chk("drain_count", 64'(count_out), 64'd0);
    // steady push and pop at count 2 across pointer wrap
    step(1, 32'h33, 32'h200, 0, 0);
    step(1, 32'h33, 32'h204, 0, 0);
    for (int i = 2; i < 12; i++) begin
      step(1, 32'h33, PW'(32'h200 + i * 4), 1, 0);
      if (i > 2) chk("stream_count", 64'(count_out), 64'd2);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // flush with 3 entries and a push in the same cycle
    for (int i = 0; i < 3; i++) step(1, 32'h13, PW'(32'h300 + i * 4), 0, 0);
    step(1, 32'hDEADBEEF, 32'h999, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_valid", 64'(dec_valid_out), 64'd0);
    step(0, 0, 0, 1, 0);
    // non-32-bit encoding followed by a legal nop
    step(1, 32'h00000010, 32'h400, 0, 0);
    step(1, 32'h00000013, 32'h404, 0, 0);
    chk("illegal_set", 64'(illegal_out), 64'd1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("illegal_clear", 64'(illegal_out), 64'd0);
    step(0, 0, 0, 0, 0);
    // asynchronous reset with 3 stored entries
    for (int i = 0; i < 3; i++) step(1, 32'h13, PW'(32'h500 + i * 4), 0, 0);
    step(0, 0, 0, 0, 0);
    @(posedge clock_in);
    #3 reset_n_in = 0;
    #1;
    chk("arst_count", 64'(count_out), 64'd0);
    chk("arst_valid", 64'(dec_valid_out), 64'd0);
    chk("arst_ready", 64'(fetch_ready_out), 64'd1);
    idle_zero("arst");
    exp_q.delete();
    push_p = 0;
    flush_p = 0;
    @(posedge clock_in);
    #2 reset_n_in = 1;
    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 1, 0);
    chk("end_count", 64'(count_out), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
